// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active low, ordered gfedcba.
package sseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/sseg_scan_ctrl_hex_to_sseg.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational lookup into the shared pattern table.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed display scanner with per-slot blanking
// and frame-aligned commit of staged values.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic [3:0]  dig_en,
    input  logic        update,
    output logic        update_ack,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [6:0]  cathode
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    logic [15:0] shadow_val_q;
    logic [3:0]  shadow_en_q;
    logic [15:0] stage_val_q;
    logic [3:0]  stage_en_q;
    logic        pending_q;

    logic [3:0] an_q;
    logic [6:0] cathode_q;
    logic       ack_q;
    logic       tick_q;

    logic       commit;
    logic       digit_on;
    logic       tick_d;
    logic [3:0] nib;
    logic [6:0] seg;
    logic [3:0] an_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        unique case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) state_d = DRIVE;
            end
            DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // Register the tick from next-state so it lines up with the last slot cycle.
    assign tick_d = (state_d == DRIVE) && (idx_d == 2'd3) &&
                    (cnt_d == SLOT_LAST);

    assign commit = tick_q && pending_q;

    always_comb begin
        nib = shadow_val_q[3:0];
        unique case (idx_q)
            2'd0: nib = shadow_val_q[3:0];
            2'd1: nib = shadow_val_q[7:4];
            2'd2: nib = shadow_val_q[11:8];
            2'd3: nib = shadow_val_q[15:12];
            default: nib = shadow_val_q[3:0];
        endcase
    end

    hex_to_sseg u_hex (
        .nib_i (nib),
        .seg_o (seg)
    );

    assign digit_on = (state_q == DRIVE) && shadow_en_q[idx_q];
    assign an_d     = ~(4'b0001 << idx_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            shadow_val_q <= 16'h0000;
            shadow_en_q  <= 4'b0000;
            stage_val_q  <= 16'h0000;
            stage_en_q   <= 4'b0000;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            cathode_q    <= SEG_OFF;
            ack_q        <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            ack_q   <= commit;
            if (commit) begin
                shadow_val_q <= stage_val_q;
                shadow_en_q  <= stage_en_q;
                pending_q    <= 1'b0;
            end
            // A same-cycle update re-arms pending after the commit above.
            if (update) begin
                stage_val_q <= value_in;
                stage_en_q  <= dig_en;
                pending_q   <= 1'b1;
            end
            an_q      <= digit_on ? an_d : AN_OFF;
            cathode_q <= digit_on ? seg  : SEG_OFF;
        end
    end

    assign an         = an_q;
    assign cathode    = cathode_q;
    assign update_ack = ack_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for the scan controller, small slot timing.
// Cycle 0 is the first cycle after reset is released.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic [3:0]  dig_en;
    logic        update;
    logic        update_ack;
    logic        frame_tick;
    logic [3:0]  an;
    logic [6:0]  cathode;

    int nvec  = 0;
    int nerr  = 0;
    int cyc   = 0;
    int acks  = 0;
    int ack_cyc = -1;

    sseg_scan_ctrl #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .dig_en     (dig_en),
        .update     (update),
        .update_ack (update_ack),
        .frame_tick (frame_tick),
        .an         (an),
        .cathode    (cathode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (update_ack) begin
            acks++;
            ack_cyc = cyc;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        update = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_an",  32'(an),         32'hF);
            check("rst_seg", 32'(cathode),    32'h7F);
            check("rst_ack", 32'(update_ack), 32'h0);
        end
        reset   = 1'b0;
        cyc     = 0;
        acks    = 0;
        ack_cyc = -1;
    endtask

    task automatic upd(input int c, input logic [15:0] v,
                       input logic [3:0] en);
        run_to(c);
        value_in = v;
        dig_en   = en;
        update   = 1'b1;
        step();
        update   = 1'b0;
    endtask

    task automatic show(input string tag, input int c,
                        input logic [3:0] ea, input logic [6:0] es);
        run_to(c);
        check({tag, "_an"},  32'(an),      32'(ea));
        check({tag, "_seg"}, 32'(cathode), 32'(es));
    endtask

    logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] exp_sg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        int on_cnt;
        logic [6:0] cap;
        value_in = 16'h0;
        dig_en   = 4'h0;
        update   = 1'b0;
        reset    = 1'b1;

        // 1: reset values, idle frames, frame_tick placement
        do_reset();
        while (cyc < 64) begin
            step();
            check("t1_tick", 32'(frame_tick),
                  32'((cyc == 31) || (cyc == 63)));
            check("t1_an", 32'(an), 32'hF);
        end
        check("t1_noack", 32'(acks), 32'd0);

        // 2: commit 1234, all digits on, 6 drive cycles per slot
        do_reset();
        upd(5, 16'h1234, 4'b1111);
        run_to(33);
        check("t2_acks", 32'(acks), 32'd1);
        check("t2_ackc", 32'(ack_cyc), 32'd32);
        for (int n = 0; n < 4; n++) begin
            run_to(32 + 8 * n);
            on_cnt = 0;
            cap    = 7'h7F;
            repeat (8) begin
                step();
                if (an == exp_an[n]) on_cnt++;
                if (cyc == 32 + 8 * n + 5) cap = cathode;
            end
            check("t2_width", 32'(on_cnt), 32'd6);
            check("t2_seg",   32'(cap),    32'(exp_sg[n]));
        end

        // 3: digit enable mask hides digits 1 and 3
        do_reset();
        upd(5, 16'h00F0, 4'b0101);
        show("t3_d0", 37, 4'b1110, 7'h40);
        show("t3_d1", 45, 4'b1111, 7'h7F);
        show("t3_d2", 53, 4'b1011, 7'h40);
        show("t3_d3", 61, 4'b1111, 7'h7F);

        // 4: second update overwrites staging, single ack
        do_reset();
        upd(3, 16'h1111, 4'b1111);
        upd(10, 16'hABCD, 4'b1111);
        show("t4_d0", 37, 4'b1110, 7'h21);
        check("t4_ackc", 32'(ack_cyc), 32'd32);
        run_to(70);
        check("t4_acks", 32'(acks), 32'd1);

        // 5: update on tick cycle with nothing pending
        do_reset();
        upd(31, 16'h5555, 4'b1111);
        run_to(40);
        check("t5_noack", 32'(acks), 32'd0);
        show("t5_d0", 69, 4'b1110, 7'h12);
        check("t5_acks", 32'(acks), 32'd1);
        check("t5_ackc", 32'(ack_cyc), 32'd64);

        // 6: reset mid-scan drops staged data
        do_reset();
        upd(5, 16'h8888, 4'b1111);
        run_to(20);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_an",  32'(an),      32'hF);
        check("t6_seg", 32'(cathode), 32'h7F);
        reset   = 1'b0;
        cyc     = 0;
        acks    = 0;
        ack_cyc = -1;
        show("t6_d0", 5, 4'b1111, 7'h7F);
        run_to(31);
        check("t6_tick", 32'(frame_tick), 32'd1);
        run_to(40);
        check("t6_noack", 32'(acks), 32'd0);
        show("t6_d0b", 37, 4'b1111, 7'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
